// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- parametrised multi-port register file (2 write lanes, NRD
// combinational read ports) with a hardware clear sequence after reset and
// optional same-cycle write-to-read bypass.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   ready                 high once the clear sequence has finished (RUN)
//   we0/waddr0/wdata0     write lane 0
//   we1/waddr1/wdata1     write lane 1 (wins over lane 0 on the same address)
//   raddr [NRD*AW]        packed read addresses, port i at [i*AW +: AW]
//   rdata [NRD*XLEN]      packed read data,      port i at [i*XLEN +: XLEN]
//
// Optional feature, enabled by defining REGFILE_MP_SCOREBOARD_EN:
//   alloc_en/alloc_addr   mark a register as pending (result outstanding)
//   busy [NRD]            per read port: addressed register is pending and
//                         not being supplied by the bypass this cycle
//
// Handshake: there is no per-transaction valid/ready. `ready` is a level:
// while it is low every write is ignored and every read port returns 0;
// while it is high writes commit on the rising edge and reads are live.
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ready,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic [NRD*AW-1:0]   raddr,
`ifdef REGFILE_MP_SCOREBOARD_EN
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic [NRD-1:0]      busy,
`endif
  output logic [NRD*XLEN-1:0] rdata
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [XLEN-1:0] regs_q [NREG];

  logic wr0_ok, wr1_ok;
  logic wr0_eff;

  // ---------------------------------------------------------------------------
  // Clear / run FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        // Last register is cleared on this edge; RUN starts right after it.
        if (clr_idx_q == AW'(NREG - 1)) begin
          state_d   = ST_RUN;
          clr_idx_d = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

  assign ready = (state_q == ST_RUN);

  // ---------------------------------------------------------------------------
  // Write qualification. A write "counts" only in RUN and, with ZERO_REG, only
  // to a non-zero address. The bypass and the scoreboard use the same terms so
  // they can never disagree with what actually commits.
  // ---------------------------------------------------------------------------
  assign wr0_ok = ready && we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wr1_ok = ready && we1 && !((ZERO_REG != 0) && (waddr1 == '0));
  // Lane 1 wins a same-address collision, so lane 0 is dropped there.
  assign wr0_eff = wr0_ok && !(wr1_ok && (waddr1 == waddr0));

  // Storage is deliberately not on the reset; the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      regs_q[clr_idx_q] <= '0;
    end else begin
      if (wr0_eff) regs_q[waddr0] <= wdata0;
      if (wr1_ok)  regs_q[waddr1] <= wdata1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [NRD-1:0] byp_hit;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            hit1, hit0;
    logic [XLEN-1:0] rd;

    assign ra   = raddr[i*AW +: AW];
    assign hit1 = (BYPASS != 0) && wr1_ok && (waddr1 == ra);
    assign hit0 = (BYPASS != 0) && wr0_ok && (waddr0 == ra);
    assign byp_hit[i] = hit1 || hit0;

    always_comb begin
      rd = '0;
      if (!ready) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
      end else if (hit1) begin
        rd = wdata1;
      end else if (hit0) begin
        rd = wdata0;
      end else begin
        rd = regs_q[ra];
      end
    end

    assign rdata[i*XLEN +: XLEN] = rd;
  end

`ifdef REGFILE_MP_SCOREBOARD_EN
  // ---------------------------------------------------------------------------
  // Pending scoreboard: alloc sets, a committed write clears, set beats clear.
  // ---------------------------------------------------------------------------
  logic [NREG-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    if (!ready) begin
      pending_d = '0;
    end else begin
      if (wr0_ok) pending_d[waddr0] = 1'b0;
      if (wr1_ok) pending_d[waddr1] = 1'b0;
      if (alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0)))
        pending_d[alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_busy
    assign busy[i] = pending_q[raddr[i*AW +: AW]] && !byp_hit[i];
  end
`else
  logic unused_byp;
  assign unused_byp = ^byp_hit;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp -- directed self-checking bench for regfile_mp (default
// parameters: XLEN=32, NREG=32, NRD=2, ZERO_REG=1, BYPASS=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// shortly after that, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                ready;
  logic                we0, we1;
  logic [AW-1:0]       waddr0, waddr1;
  logic [XLEN-1:0]     wdata0, wdata1;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
`ifdef REGFILE_MP_SCOREBOARD_EN
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic [NRD-1:0]      busy;
`endif

  regfile_mp #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ready     (ready),
    .we0       (we0),
    .waddr0    (waddr0),
    .wdata0    (wdata0),
    .we1       (we1),
    .waddr1    (waddr1),
    .wdata1    (wdata1),
    .raddr     (raddr),
`ifdef REGFILE_MP_SCOREBOARD_EN
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .busy      (busy),
`endif
    .rdata     (rdata)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_mis = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    raddr = '0;
`ifdef REGFILE_MP_SCOREBOARD_EN
    alloc_en = 1'b0; alloc_addr = '0;
`endif
  endtask

  task automatic set_ra(input int port, input logic [AW-1:0] a);
    raddr[port*AW +: AW] = a;
  endtask

  function automatic logic [XLEN-1:0] rd(input int port);
    return rdata[port*XLEN +: XLEN];
  endfunction

  // Count rising edges until ready is seen high; bounded.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      cycles++;
      if (ready) break;
    end
  endtask

  // Read every register through both ports and compare with exp_q contents.
  task automatic scan_all(input string tag);
    logic [XLEN-1:0] e;
    for (int r = 0; r < NREG; r += 2) begin
      set_ra(0, AW'(r));
      set_ra(1, AW'(r + 1));
      #1;
      e = exp_q.pop_front();
      check_eq($sformatf("%s_r%0d", tag, r), rd(0), e);
      e = exp_q.pop_front();
      check_eq($sformatf("%s_r%0d", tag, r + 1), rd(1), e);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int cyc;

  initial begin
    idle_inputs();
    #12;
    check_eq("reset_ready", ready, 0);
    check_eq("reset_rdata", rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready(cyc);
    check_eq("first_clear_cycles", cyc, NREG);

    // Fill every register with DEADBEEF, two per cycle.
    for (int r = 0; r < NREG; r += 2) begin
      we0 = 1'b1; waddr0 = AW'(r);     wdata0 = 32'hDEAD_BEEF;
      we1 = 1'b1; waddr1 = AW'(r + 1); wdata1 = 32'hDEAD_BEEF;
      tick();
    end
    idle_inputs();
    exp_q.push_back(32'h0);  // register 0 is hard zero
    for (int r = 1; r < NREG; r++) exp_q.push_back(32'hDEAD_BEEF);
    scan_all("fill");

    // Reset + clear, with lane 0 hammering address 5 throughout.
    rst_n = 1'b0;
    #3;
    check_eq("rst_ready_low", ready, 0);
    tick();
    rst_n = 1'b1;
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h5555_5555;
    set_ra(0, 5'd5);
    #1;
    check_eq("clear_rdata_zero", rd(0), 0);
    wait_ready(cyc);
    check_eq("clear_cycles", cyc, NREG);
    idle_inputs();
    for (int r = 0; r < NREG; r++) exp_q.push_back(32'h0);
    scan_all("cleared");

    // Basic dual-lane write.
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234_5678;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hCAFE_F00D;
    tick();
    idle_inputs();
    set_ra(0, 5'd5); set_ra(1, 5'd9);
    #1;
    check_eq("basic_p0", rd(0), 32'h1234_5678);
    check_eq("basic_p1", rd(1), 32'hCAFE_F00D);

    // Lane 0 bypass, and stored value is still old before the edge.
    we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h0000_A5A5;
    set_ra(0, 5'd10); set_ra(1, 5'd5);
    #1;
    check_eq("byp0_p0", rd(0), 32'h0000_A5A5);
    check_eq("byp0_p1_unrelated", rd(1), 32'h1234_5678);
    tick();
    idle_inputs();
    set_ra(1, 5'd10);
    #1;
    check_eq("byp0_committed", rd(1), 32'h0000_A5A5);

    // Collision: lane 1 wins, also on the bypass.
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1111;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2222;
    set_ra(0, 5'd7);
    #1;
    check_eq("collide_bypass", rd(0), 32'h2222);
    tick();
    idle_inputs();
    set_ra(1, 5'd7);
    #1;
    check_eq("collide_stored", rd(1), 32'h2222);

    // Zero register.
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
    set_ra(0, 5'd0);
    #1;
    check_eq("zero_same_cycle", rd(0), 0);
    tick();
    idle_inputs();
    set_ra(1, 5'd0);
    #1;
    check_eq("zero_later", rd(1), 0);

`ifdef REGFILE_MP_SCOREBOARD_EN
    // Scoreboard: alloc, then write-back clears busy via bypass.
    alloc_en = 1'b1; alloc_addr = 5'd3;
    tick();
    alloc_en = 1'b0;
    tick();
    tick();
    set_ra(1, 5'd3);
    #1;
    check_eq("sb_busy_set", busy[1], 1);
    check_eq("sb_busy_other_port", busy[0], 0);
    we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hAB;
    #1;
    check_eq("sb_busy_bypass", busy[1], 0);
    check_eq("sb_rdata_bypass", rd(1), 32'hAB);
    tick();
    we1 = 1'b0;
    #1;
    check_eq("sb_busy_after", busy[1], 0);
    check_eq("sb_rdata_after", rd(1), 32'hAB);
    idle_inputs();
`endif

    // Reset in the middle of clear: 12 registers cleared, then restart.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    check_eq("midclear_ready_low", ready, 0);
    rst_n = 1'b0;
    tick();
    tick();
    check_eq("midclear_in_reset", ready, 0);
    rst_n = 1'b1;
    wait_ready(cyc);
    check_eq("midclear_full_clear", cyc, NREG);
    set_ra(0, 5'd9); set_ra(1, 5'd7);
    #1;
    check_eq("midclear_r9_zero", rd(0), 0);
    check_eq("midclear_r7_zero", rd(1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_mis++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
